gray_counter_sync: RTL and testbench

Parametrised synchronous Gray-code counter for multi-bit values that cross clock domains, such as FIFO pointers and position codes. Holds a binary count and presents both the binary and the registered Gray encoding. Supports up/down counting, enable and a parallel load of a Gray-coded value, with a terminal-event pulse. It supersedes the combinational-only G2B/B2G conversion with a clocked, width-generic counter.

---
 rtl/gray_counter_sync.sv | 75 +++++++
 tb/tb_gray_counter_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_sync.sv
// Width-generic synchronous Gray-code counter with up/down, enable, Gray load and a terminal-event pulse.
// Define GRAY_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module gray_counter_sync #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    // Prefix XOR from the MSB down: each binary bit folds in every Gray bit above it.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    localparam logic [WIDTH-1:0] RST_BIN = g2b(RST_GRAY);
    localparam logic [WIDTH-1:0] MAX_BIN = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             terminal;

    assign terminal = up ? (bin_q == MAX_BIN) : (bin_q == '0);

    always_comb begin
        // NOTE: every next-state value gets a default first so no branch can infer a latch.
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = g2b(load_gray);
        end else if (en) begin
            wrap_d = terminal;
`ifdef GRAY_COUNTER_SAT_EN
            if (!terminal) begin
                bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
            end
`else
            bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
`endif
        end
        // Gray is registered from the next binary value so the output never decodes bin_q.
        gray_d = load ? load_gray : (bin_d ^ (bin_d >> 1));
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all three update together on the edge.
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_sync.sv
// Self-checking bench for gray_counter_sync (WIDTH=5, RST_GRAY=0): directed table, corner sequences,
// and randomized traffic against a reflected-Gray-table reference model.
module tb_gray_counter_sync;

    localparam int W = 5;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         wrap;

    gray_counter_sync #(.WIDTH(W), .RST_GRAY(5'b00000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_gray (load_gray),
        .gray      (gray),
        .bin       (bin),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: Gray code as the reflected sequence, count as a plain integer.
    int gray_of[N];
    int m_cnt  = 0;
    int m_wrap = 0;

    function automatic int gray_index(input int g);
        for (int i = 0; i < N; i++) if (gray_of[i] == g) return i;
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic u, input logic l, input int g);
        int term;
        if (r) begin
            m_cnt  = gray_index(0);
            m_wrap = 0;
        end else if (l) begin
            m_cnt  = gray_index(g);
            m_wrap = 0;
        end else if (e) begin
            term   = u ? (m_cnt == N - 1) : (m_cnt == 0);
            m_wrap = term;
`ifdef GRAY_COUNTER_SAT_EN
            if (!term) m_cnt = u ? m_cnt + 1 : m_cnt - 1;
`else
            m_cnt = u ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
`endif
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic u, input logic l, input logic [W-1:0] g);
        rst = r; en = e; up = u; load = l; load_gray = g;
        @(posedge clk);
        model_update(r, e, u, l, int'(g));
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".bin"},  int'(bin),  m_cnt);
        check({tag, ".gray"}, int'(gray), gray_of[m_cnt]);
        check({tag, ".wrap"}, int'(wrap), m_wrap);
    endtask

    typedef struct {
        logic         r, e, u, l;
        logic [W-1:0] g;
        int           exp_bin, exp_gray, exp_wrap;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int size;
        int prev_gray;
        int prev_cnt;

        gray_of[0] = 0;
        for (int n = 1; n <= W; n++) begin
            size = 1 << (n - 1);
            for (int i = 0; i < size; i++) gray_of[2 * size - 1 - i] = gray_of[i] | size;
        end

        //          rst   en    up    load  load_gray  bin gray wrap
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00111,  0,  0,  0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00111,  0,  0,  0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00011,  2,  3,  0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00000,  3,  2,  0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11111, 21, 31,  0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00011,  0,  0,  0};
`ifdef GRAY_COUNTER_SAT_EN
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000,  0,  0,  1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000,  0,  0,  1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000,  0,  0,  0};
`else
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 31, 16,  1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 30, 17,  0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 30, 17,  0};
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].g);
            check($sformatf("vec%0d.bin", i),  int'(bin),  vecs[i].exp_bin);
            check($sformatf("vec%0d.gray", i), int'(gray), vecs[i].exp_gray);
            check($sformatf("vec%0d.wrap", i), int'(wrap), vecs[i].exp_wrap);
        end

        // Full up-sweep from 0: single-bit Gray transitions and the terminal step.
        apply(1'b1, 1'b0, 1'b0, 1'b0, '0);
        prev_gray = int'(gray);
        for (int s = 1; s <= N; s++) begin
            prev_cnt = m_cnt;
            apply(1'b0, 1'b1, 1'b1, 1'b0, '0);
            check_model($sformatf("sweep%0d", s));
            if (m_cnt != prev_cnt)
                check($sformatf("sweep%0d.hamming", s), $countones(prev_gray ^ int'(gray)), 1);
            if (s == N - 1) check("sweep.gray_at_31", int'(gray), 16);
            prev_gray = int'(gray);
        end
`ifdef GRAY_COUNTER_SAT_EN
        check("sweep.end_bin", int'(bin), 31);
`else
        check("sweep.end_bin", int'(bin), 0);
`endif
        check("sweep.end_wrap", int'(wrap), 1);
        apply(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("sweep.wrap_one_cycle", int'(wrap), 0);

`ifdef GRAY_COUNTER_SAT_EN
        // Pushing against the upper limit: bin holds and wrap stays high.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 5'b10000);
        check("sat.load_bin", int'(bin), 31);
        for (int s = 0; s < 3; s++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, '0);
            check($sformatf("sat%0d.bin", s), int'(bin), 31);
            check($sformatf("sat%0d.wrap", s), int'(wrap), 1);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("sat.down_bin", int'(bin), 30);
        check("sat.down_wrap", int'(wrap), 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            prev_gray = int'(gray);
            prev_cnt  = m_cnt;
            apply($urandom_range(49) == 0, $urandom_range(3) != 0, 1'($urandom),
                  $urandom_range(9) == 0, W'($urandom));
            check_model($sformatf("rand%0d", c));
            if (!rst && !load && en && m_cnt != prev_cnt)
                check($sformatf("rand%0d.hamming", c), $countones(prev_gray ^ int'(gray)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
